ahb2_apb_bridge: RTL and testbench

- AHB2 slave-side bridge to an AMBA2 APB peripheral bus (no pready/pslverr).
- Consumes the slave-side signal set (hsel, haddr, htrans, hwrite, hwdata, hreadyi; returns hrdata, hreadyo, hresp) produced by the AHB2 decoder/mux.
- Converts each AHB transfer into one APB SETUP+ACCESS sequence.
- Decodes a one-hot psel from a field of the address.

---
 rtl/ahb2_apb_bridge_pkg.sv | 45 ++++
 rtl/ahb2_apb_bridge_if.sv | 41 ++++
 rtl/ahb2_apb_bridge.sv | 110 +++++++++++
 tb/tb_ahb2_apb_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2_apb_bridge_pkg.sv
// AHB2 bus codes, bridge state type and the APB select decoder
// shared by the AHB2-to-APB bridge slice.
package ahb2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        WWAIT,
        SETUP,
        ACCESS
    } bridge_state_t;

    function automatic logic [31:0] onehot(input int unsigned idx,
                                           input int unsigned cnt);
        logic [31:0] v;
        v = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == idx && i < cnt) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ahb2_apb_bridge_if.sv
// Slave-side AHB2 signals and APB master signals of the bridge.
// The bridge uses the slave view; the driving fabric uses master.
interface ahb2_apb_bridge_if #(
    parameter int PADDR_W  = 16,
    parameter int PSEL_CNT = 4
);

    logic                hsel;
    logic [31:0]         haddr;
    logic [1:0]          htrans;
    logic                hwrite;
    logic [2:0]          hsize;
    logic [2:0]          hburst;
    logic [3:0]          hprot;
    logic [31:0]         hwdata;
    logic                hreadyi;
    logic [31:0]         hrdata;
    logic                hreadyo;
    logic [1:0]          hresp;
    logic [PSEL_CNT-1:0] psel;
    logic                penable;
    logic [PADDR_W-1:0]  paddr;
    logic                pwrite;
    logic [31:0]         pwdata;
    logic [31:0]         prdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst,
        input  hprot, hwdata, hreadyi, prdata,
        output hrdata, hreadyo, hresp,
        output psel, penable, paddr, pwrite, pwdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst,
        output hprot, hwdata, hreadyi, prdata,
        input  hrdata, hreadyo, hresp,
        input  psel, penable, paddr, pwrite, pwdata
    );

endinterface

// File: rtl/ahb2_apb_bridge.sv
// AHB2 slave to AMBA2 APB bridge: each accepted AHB transfer
// becomes one APB SETUP+ACCESS pair, writes first wait for hwdata.
module ahb2_apb_bridge
    import ahb2_pkg::*;
#(
    parameter int PADDR_W  = 16,
    parameter int PSEL_CNT = 4,
    parameter int PSEL_LSB = 12
) (
    input  logic              hclk,
    input  logic              hreset_n,
    ahb2_apb_bridge_if.slave  bus
);

    localparam int SEL_W = $clog2(PSEL_CNT);

    bridge_state_t       state_q, state_d;
    logic [PADDR_W-1:0]  a_addr_q, a_addr_d;
    logic [PSEL_CNT-1:0] a_sel_q, a_sel_d;
    logic                a_write_q, a_write_d;
    logic [PSEL_CNT-1:0] psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [PADDR_W-1:0]  paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         pwdata_q, pwdata_d;

    logic        acc;
    logic [31:0] sel_oh;
    logic        unused_bits;

    assign acc    = bus.hsel & bus.hreadyi & bus.htrans[1];
    assign sel_oh = onehot(int'(bus.haddr[PSEL_LSB +: SEL_W]), PSEL_CNT);

    always_comb begin
        state_d   = state_q;
        a_addr_d  = a_addr_q;
        a_sel_d   = a_sel_q;
        a_write_d = a_write_q;
        pwdata_d  = pwdata_q;
        unique case (state_q)
            IDLE, ACCESS: begin
                state_d = IDLE;
                if (acc) begin
                    state_d   = bus.hwrite ? WWAIT : SETUP;
                    a_addr_d  = bus.haddr[PADDR_W-1:0];
                    a_sel_d   = sel_oh[PSEL_CNT-1:0];
                    a_write_d = bus.hwrite;
                end
            end
            WWAIT: begin
                pwdata_d = bus.hwdata;
                state_d  = SETUP;
            end
            SETUP:   state_d = ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // APB outputs are registered, so they follow the next state
    always_comb begin
        psel_d    = '0;
        penable_d = 1'b0;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        if (state_d == SETUP || state_d == ACCESS) psel_d = a_sel_d;
        if (state_d == ACCESS) penable_d = 1'b1;
        if (state_d == SETUP) begin
            paddr_d  = a_addr_d;
            pwrite_d = a_write_d;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= IDLE;
            a_addr_q  <= '0;
            a_sel_q   <= '0;
            a_write_q <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_addr_q  <= a_addr_d;
            a_sel_q   <= a_sel_d;
            a_write_q <= a_write_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.paddr   = paddr_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.hreadyo = (state_q == IDLE) || (state_q == ACCESS);
    assign bus.hrdata  = (state_q == ACCESS && !a_write_q) ? bus.prdata : '0;
    assign bus.hresp   = HRESP_OKAY;

    // word-only bridge: size, burst, protection and upper address unused
    assign unused_bits = ^{bus.haddr, bus.htrans[0], bus.hsize,
                           bus.hburst, bus.hprot, sel_oh};

endmodule

// File: tb/tb_ahb2_apb_bridge.sv
// Directed vector table plus randomized traffic checked against a
// per-transfer schedule model of the AHB2-to-APB bridge.
module tb_ahb2_apb_bridge;

    localparam int N = 1500;

    typedef struct {
        logic        hsel;
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] hwdata;
        logic        hreadyi;
        logic [31:0] prdata;
    } in_t;

    // m[0]: check paddr, m[1]: check pwrite, m[2]: check pwdata
    typedef struct {
        logic        rdy;
        logic [3:0]  psel;
        logic        pen;
        logic [15:0] paddr;
        logic        pw;
        logic [31:0] pwdata;
        logic [31:0] hrdata;
        logic [2:0]  m;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ahb2_apb_bridge_if #(.PADDR_W(16), .PSEL_CNT(4)) bus();

    ahb2_apb_bridge #(
        .PADDR_W (16),
        .PSEL_CNT(4),
        .PSEL_LSB(12)
    ) dut (
        .hclk    (clk),
        .hreset_n(rst_n),
        .bus     (bus.slave)
    );

    function automatic in_t ai(logic hs, logic [31:0] a, logic [1:0] t,
                               logic w, logic [31:0] wd, logic hr,
                               logic [31:0] pr);
        in_t v;
        v.hsel = hs; v.haddr = a; v.htrans = t; v.hwrite = w;
        v.hwdata = wd; v.hreadyi = hr; v.prdata = pr;
        return v;
    endfunction

    function automatic exp_t ae(logic rdy, logic [3:0] ps, logic pen,
                                logic [15:0] pa, logic pw,
                                logic [31:0] pwd, logic [31:0] hrd,
                                logic [2:0] m);
        exp_t e;
        e.rdy = rdy; e.psel = ps; e.pen = pen; e.paddr = pa; e.pw = pw;
        e.pwdata = pwd; e.hrdata = hrd; e.m = m;
        return e;
    endfunction

    task automatic drive(input in_t v);
        bus.hsel    = v.hsel;
        bus.haddr   = v.haddr;
        bus.htrans  = v.htrans;
        bus.hwrite  = v.hwrite;
        bus.hwdata  = v.hwdata;
        bus.hreadyi = v.hreadyi;
        bus.prdata  = v.prdata;
    endtask

    task automatic step(input in_t v);
        @(negedge clk);
        drive(v);
        #1;
    endtask

    task automatic check(input string nm, input exp_t e);
        logic [88:0] a, x, mk;
        a  = {bus.hreadyo, bus.hresp, bus.psel, bus.penable, bus.paddr,
              bus.pwrite, bus.pwdata, bus.hrdata};
        x  = {e.rdy, 2'b00, e.psel, e.pen, e.paddr, e.pw, e.pwdata,
              e.hrdata};
        mk = {1'b1, 2'b11, 4'hf, 1'b1, {16{e.m[0]}}, e.m[1],
              {32{e.m[2]}}, 32'hffff_ffff};
        n_chk++;
        if ((a & mk) === (x & mk)) n_pass++;
        else $display("FAIL %s: got %h expected %h mask %h",
                      nm, a, x, mk);
    endtask

    vec_t tbl[$];
    in_t  stim[N+1];
    exp_t q[$];
    in_t  idl;

    initial begin
        idl = ai(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0);
        bus.hsize  = 3'b010;
        bus.hburst = 3'b000;
        bus.hprot  = 4'b0011;
        drive(idl);

        // single write to slave 2
        tbl.push_back('{ai(1,32'h2010,2'b10,1,0,1,0),
                        ae(1,4'h0,0,16'h0,0,32'h0,0,7)});
        tbl.push_back('{ai(0,0,2'b00,0,32'hDEADBEEF,1,0),
                        ae(0,4'h0,0,16'h0,0,32'h0,0,7)});
        tbl.push_back('{idl, ae(0,4'h4,0,16'h2010,1,32'hDEADBEEF,0,7)});
        tbl.push_back('{idl, ae(1,4'h4,1,16'h2010,1,32'hDEADBEEF,0,7)});
        tbl.push_back('{idl, ae(1,4'h0,0,16'h2010,1,32'hDEADBEEF,0,7)});
        // single read from slave 1
        tbl.push_back('{ai(1,32'h1004,2'b10,0,0,1,32'h12345678),
                        ae(1,4'h0,0,16'h2010,1,32'hDEADBEEF,0,7)});
        tbl.push_back('{ai(0,0,2'b00,0,0,1,32'h12345678),
                        ae(0,4'h2,0,16'h1004,0,32'hDEADBEEF,0,7)});
        tbl.push_back('{ai(0,0,2'b00,0,0,1,32'h12345678),
                        ae(1,4'h2,1,16'h1004,0,32'hDEADBEEF,
                           32'h12345678,7)});
        tbl.push_back('{ai(0,0,2'b00,0,0,1,32'h12345678),
                        ae(1,4'h0,0,16'h1004,0,32'hDEADBEEF,0,7)});
        // read then pipelined write
        tbl.push_back('{ai(1,32'h3000,2'b10,0,0,1,32'hCAFEF00D),
                        ae(1,4'h0,0,16'h1004,0,32'hDEADBEEF,0,7)});
        tbl.push_back('{ai(0,0,2'b00,0,0,1,32'hCAFEF00D),
                        ae(0,4'h8,0,16'h3000,0,32'hDEADBEEF,0,7)});
        tbl.push_back('{ai(1,32'h0008,2'b10,1,0,1,32'hCAFEF00D),
                        ae(1,4'h8,1,16'h3000,0,32'hDEADBEEF,
                           32'hCAFEF00D,7)});
        tbl.push_back('{ai(0,0,2'b00,0,32'hA5A5A5A5,1,0),
                        ae(0,4'h0,0,16'h0,0,32'hDEADBEEF,0,4)});
        tbl.push_back('{idl, ae(0,4'h1,0,16'h0008,1,32'hA5A5A5A5,0,7)});
        tbl.push_back('{idl, ae(1,4'h1,1,16'h0008,1,32'hA5A5A5A5,0,7)});
        tbl.push_back('{idl, ae(1,4'h0,0,16'h0008,1,32'hA5A5A5A5,0,7)});
        // ignored: BUSY, hreadyi low, hsel low
        tbl.push_back('{ai(1,32'h3000,2'b01,1,0,1,0),
                        ae(1,4'h0,0,16'h0008,1,32'hA5A5A5A5,0,7)});
        tbl.push_back('{ai(1,32'h1000,2'b10,0,0,0,0),
                        ae(1,4'h0,0,16'h0008,1,32'hA5A5A5A5,0,7)});
        tbl.push_back('{ai(0,32'h2000,2'b10,1,0,1,0),
                        ae(1,4'h0,0,16'h0008,1,32'hA5A5A5A5,0,7)});
        tbl.push_back('{idl, ae(1,4'h0,0,16'h0008,1,32'hA5A5A5A5,0,7)});
        // select sweep, upper haddr bits set, reads chained via SEQ
        tbl.push_back('{ai(1,32'hFFFF0004,2'b10,0,0,1,0),
                        ae(1,4'h0,0,16'h0008,1,32'hA5A5A5A5,0,7)});
        tbl.push_back('{idl, ae(0,4'h1,0,16'h0004,0,32'hA5A5A5A5,0,7)});
        tbl.push_back('{ai(1,32'hABCD1008,2'b11,0,0,1,32'h11111111),
                        ae(1,4'h1,1,16'h0004,0,32'hA5A5A5A5,
                           32'h11111111,7)});
        tbl.push_back('{idl, ae(0,4'h2,0,16'h1008,0,32'hA5A5A5A5,0,7)});
        tbl.push_back('{ai(1,32'h5555200C,2'b11,0,0,1,32'h22222222),
                        ae(1,4'h2,1,16'h1008,0,32'hA5A5A5A5,
                           32'h22222222,7)});
        tbl.push_back('{idl, ae(0,4'h4,0,16'h200C,0,32'hA5A5A5A5,0,7)});
        tbl.push_back('{ai(1,32'h00013010,2'b10,0,0,1,32'h33333333),
                        ae(1,4'h4,1,16'h200C,0,32'hA5A5A5A5,
                           32'h33333333,7)});
        tbl.push_back('{ai(0,0,2'b00,0,0,1,32'h44444444),
                        ae(0,4'h8,0,16'h3010,0,32'hA5A5A5A5,0,7)});
        tbl.push_back('{ai(0,0,2'b00,0,0,1,32'h44444444),
                        ae(1,4'h8,1,16'h3010,0,32'hA5A5A5A5,
                           32'h44444444,7)});
        tbl.push_back('{idl, ae(1,4'h0,0,16'h3010,0,32'hA5A5A5A5,0,7)});

        // reset state, then release away from the clock edge
        step(idl);
        check("reset_state", ae(1,4'h0,0,16'h0,0,32'h0,0,7));
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i);
            check($sformatf("vec%0d", k), tbl[k].e);
        end

        // reset asserted in ACCESS with a pipelined write pending
        step(ai(1,32'h2004,2'b10,0,0,1,32'h77777777));
        step(ai(0,0,2'b00,0,0,1,32'h77777777));
        step(ai(1,32'h1000,2'b10,1,0,1,32'h77777777));
        check("pre_reset_access",
              ae(1,4'h4,1,16'h2004,0,32'hA5A5A5A5,32'h77777777,7));
        rst_n = 1'b0;
        #1;
        check("reset_async", ae(1,4'h0,0,16'h0,0,32'h0,0,7));
        for (int k = 0; k < 2; k++) begin
            step(ai(1,32'h2000,2'b10,1,32'h1,1,32'h1));
            check("reset_hold", ae(1,4'h0,0,16'h0,0,32'h0,0,7));
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(idl);
        #1;
        check("after_reset", ae(1,4'h0,0,16'h0,0,32'h0,0,7));

        // randomized traffic against the schedule model
        for (int k = 0; k <= N; k++) begin
            stim[k].hsel    = ($urandom_range(0, 3) != 0);
            stim[k].haddr   = $urandom;
            stim[k].htrans  = 2'($urandom_range(0, 3));
            stim[k].hwrite  = 1'($urandom_range(0, 1));
            stim[k].hwdata  = $urandom;
            stim[k].hreadyi = ($urandom_range(0, 6) != 0);
            stim[k].prdata  = $urandom;
        end
        for (int k = 0; k < N; k++) begin
            exp_t        e;
            logic [3:0]  sel;
            logic [15:0] a;
            step(stim[k]);
            if (q.size() > 0) e = q.pop_front();
            else e = ae(1,4'h0,0,16'h0,0,32'h0,0,0);
            e.hrdata = (e.pen && !e.pw) ? stim[k].prdata : 32'h0;
            check("rand", e);
            if (e.rdy && stim[k].hsel && stim[k].hreadyi &&
                stim[k].htrans[1]) begin
                sel = 4'(1 << stim[k].haddr[13:12]);
                a   = stim[k].haddr[15:0];
                if (stim[k].hwrite) begin
                    q.push_back(ae(0,4'h0,0,16'h0,0,32'h0,0,0));
                    q.push_back(ae(0,sel,0,a,1,stim[k+1].hwdata,0,7));
                    q.push_back(ae(1,sel,1,a,1,stim[k+1].hwdata,0,7));
                end else begin
                    q.push_back(ae(0,sel,0,a,0,32'h0,0,3));
                    q.push_back(ae(1,sel,1,a,0,32'h0,0,3));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
